fp_max_reduce: RTL
==================

Name: fp_max_reduce

Overview:
Streaming max-reduction stage that consumes a burst of IEEE-754 operands and returns the largest value and the index of its first occurrence.
- Sits downstream of the operand buffers and uses a two-input magnitude/sign compare core, one comparison per accepted element, to keep a running maximum.
- Uses valid/ready handshakes on both sides. Intended for pooling/argmax use in the FPU datapath.

Parameters:
NEXP, 8, exponent field width
NSIG, 23, stored significand width; word width W = NEXP+NSIG+1
CNT_W, 8, width of the length and index fields; maximum burst length 2^CNT_W-1

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a reduction; sampled only in IDLE
len  in  CNT_W  number of elements in the burst; sampled with start
in_valid  in  1  in_data is valid
in_ready  out  1  block accepts in_data this cycle
in_data  in  W  operand {sign, exp, sig}
out_valid  out  1  result is valid
out_ready  in  1  consumer accepts the result
out_data  out  W  maximum value, or canonical qNaN
out_index  out  CNT_W  zero-based index of the selected element
out_nan  out  1  at least one NaN was seen in the burst
busy  out  1  high whenever the block is not in IDLE

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - in_ready=0, out_valid=0, busy=0, out_data=0, out_index=0, out_nan=0.
  - Accumulator, count and nan-sticky are cleared.
  - Reset mid-burst discards all partial state. The upstream must restart the burst.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 and len!=0: latch len, count=0, nan_sticky=0, go to ACCUM.
  - start=1 and len==0: go to DONE with out_data = -inf {1, all-ones exp, 0 sig}, out_index=0, out_nan=0.
  - start is ignored in every other state.
- ACCUM:
  - in_ready=1 combinationally. An element is accepted when in_valid && in_ready.
  - Element with count==0: acc=in_data, idx=0.
  - Later elements: acc/idx update only if in_data is strictly greater than acc (per fp_max2). Ties keep the earlier index.
  - NaN input (exp all-ones, sig!=0):
    - If nan_sticky=0: set nan_sticky and set idx=count.
    - acc is never loaded from a NaN.
    - Once nan_sticky=1, idx is frozen.
  - count increments on each accept.
  - When the accepted element has count==len-1, go to DONE next cycle; in_ready drops that same next cycle.
- DONE:
  - out_valid=1.
  - out_data = nan_sticky ? canonical qNaN {0, all-ones exp, 1, zeros} : acc.
  - out_index = idx, out_nan = nan_sticky.
  - Outputs hold stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE; out_valid=0 the next cycle.
  - A start in that same cycle is ignored.
- Latency: out_valid rises exactly 1 cycle after the last element is accepted. Throughput is 1 element/cycle.
- Ordering (fp_max2, strictly a > b):
  - Differing signs: the positive operand is greater. This includes +0 > -0.
  - Both positive: compare {exp, sig} as unsigned; larger wins.
  - Both negative: the smaller {exp, sig} wins.
  - Equal bit patterns: not greater.
  - Infinities order naturally.
  - Denormals compare by raw bits, with no flush.
- Width rules: count and idx are CNT_W bits. len=2^CNT_W-1 must complete without count wrap.

Decomposition:
- Package fp_pkg holds:
  - NEXP, NSIG, W.
  - State enum {IDLE, ACCUM, DONE}.
  - Constants QNAN and NEG_INF.
  - Helper functions is_nan and is_inf.
- Sub-module fp_max2: combinational, inputs a and b (W bits), output a_gt_b. Implements the ordering above. It is instantiated once in fp_max_reduce.

Test Plan:
- Basic max: len=4, stream 0x3F800000, 0xC0400000, 0x40000000, 0x40000000 -> out_data=0x40000000, out_index=2, out_nan=0, out_valid 1 cycle after the 4th accept.
- Negatives: len=3, stream 0xC0400000, 0xBF800000, 0xC0000000 -> out_data=0xBF800000, out_index=1.
- Signed zero and infinity: len=3, stream 0x80000000, 0x00000000, 0xFF800000 -> out_data=0x00000000, out_index=1. A separate burst with 0x7F800000 -> out_data=0x7F800000.
- NaN: len=4, stream 0x3F800000, 0x7FC00001, 0x40000000, 0xFFC00000 -> out_data=0x7FC00000, out_nan=1, out_index=1.
- Handshake edges:
  - len=0 -> out_data=0xFF800000 in DONE the next cycle.
  - in_valid gaps of 3 cycles do not change the result.
  - out_ready low for 5 cycles -> outputs held, and start pulses are ignored.
- Reset mid-burst: assert rst after 2 of 4 elements are accepted -> busy=0, in_ready=0, out_valid=0 immediately. A fresh burst of len=1 with 0x3F800000 -> out_data=0x3F800000, out_index=0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point max-reduction slice.
//   NEXP, NSIG, W    : default IEEE-754 single-precision field widths
//   state_t          : reduction FSM states
//   QNAN, NEG_INF    : canonical quiet NaN and negative infinity at default width
//   is_nan, is_inf   : classifiers for any format up to 64 bits wide
package fp_pkg;

  localparam int NEXP = 8;
  localparam int NSIG = 23;
  localparam int W    = NEXP + NSIG + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [W-1:0] QNAN    = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
  localparam logic [W-1:0] NEG_INF = {1'b1, {NEXP{1'b1}}, {NSIG{1'b0}}};

  // The operand is zero-extended into 64 bits so one function serves any
  // format; nexp/nsig are elaboration constants at every call site.
  function automatic logic is_nan(input logic [63:0] x, input int nexp, input int nsig);
    logic [63:0] sig_mask;
    logic [63:0] exp_mask;
    sig_mask = (64'd1 << nsig) - 64'd1;
    exp_mask = ((64'd1 << nexp) - 64'd1) << nsig;
    return ((x & exp_mask) == exp_mask) && ((x & sig_mask) != 64'd0);
  endfunction

  function automatic logic is_inf(input logic [63:0] x, input int nexp, input int nsig);
    logic [63:0] sig_mask;
    logic [63:0] exp_mask;
    sig_mask = (64'd1 << nsig) - 64'd1;
    exp_mask = ((64'd1 << nexp) - 64'd1) << nsig;
    return ((x & exp_mask) == exp_mask) && ((x & sig_mask) == 64'd0);
  endfunction

endpackage

// File: rtl/fp_max2.sv
// Two-input ordering core: a_gt_b is high when a is strictly greater than b.
//   a, b    : IEEE-754 operands {sign, exp, sig}
//   a_gt_b  : strict greater-than; equal bit patterns give 0
// Sign-magnitude ordering on raw bits: +0 > -0, infinities order naturally,
// denormals compare without flushing. NaN operands are not handled here; the
// caller screens them out.
module fp_max2 #(
  parameter int NEXP = 8,
  parameter int NSIG = 23,
  localparam int W   = NEXP + NSIG + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         a_gt_b
);

  logic         w_sign_a;
  logic         w_sign_b;
  logic [W-2:0] w_mag_a;
  logic [W-2:0] w_mag_b;

  assign w_sign_a = a[W-1];
  assign w_sign_b = b[W-1];
  assign w_mag_a  = a[W-2:0];
  assign w_mag_b  = b[W-2:0];

  // NOTE: every branch of an always_comb must assign every output (here via
  // the default first), otherwise synthesis infers a latch.
  always_comb begin
    a_gt_b = 1'b0;
    if (w_sign_a != w_sign_b) begin
      a_gt_b = ~w_sign_a;
    end else if (!w_sign_a) begin
      a_gt_b = (w_mag_a > w_mag_b);
    end else begin
      // Both negative: the smaller magnitude is the larger value.
      a_gt_b = (w_mag_a < w_mag_b);
    end
  end

endmodule

// File: rtl/fp_max_reduce.sv
// Streaming max-reduction: accepts a burst of len IEEE-754 operands and
// returns the largest value and the zero-based index of its first occurrence.
//   clk, rst            : clock, asynchronous active-high reset
//   start, len          : launch a burst of len elements (sampled in IDLE only)
//   in_valid/in_ready   : operand handshake, in_data = {sign, exp, sig}
//   out_valid/out_ready : result handshake
//   out_data            : maximum, or canonical qNaN if any NaN was seen
//   out_index           : index of the selected element (first NaN if any)
//   out_nan             : at least one NaN in the burst
//   busy                : block is not IDLE
module fp_max_reduce
  import fp_pkg::*;
#(
  parameter int NEXP  = fp_pkg::NEXP,
  parameter int NSIG  = fp_pkg::NSIG,
  parameter int CNT_W = 8,
  localparam int W    = NEXP + NSIG + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_index,
  output logic             out_nan,
  output logic             busy
);

  localparam logic [W-1:0] QNAN_W    = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
  localparam logic [W-1:0] NEG_INF_W = {1'b1, {NEXP{1'b1}}, {NSIG{1'b0}}};

  state_t           r_state;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_count;
  logic [W-1:0]     r_acc;
  logic [CNT_W-1:0] r_idx;
  logic             r_nan;

  logic             w_accept;
  logic             w_in_nan;
  logic             w_in_gt;
  logic             w_last;

  fp_max2 #(
    .NEXP (NEXP),
    .NSIG (NSIG)
  ) u_max2 (
    .a      (in_data),
    .b      (r_acc),
    .a_gt_b (w_in_gt)
  );

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

  assign w_accept  = in_valid && in_ready;
  assign w_in_nan  = is_nan(64'(in_data), NEXP, NSIG);
  // count never exceeds len-1, so len = 2^CNT_W-1 finishes before any wrap.
  assign w_last    = (r_count == r_len - CNT_W'(1));

  // Outputs are forced to zero outside DONE so nothing stale leaks out.
  assign out_data  = !out_valid ? '0 : (r_nan ? QNAN_W : r_acc);
  assign out_index = out_valid ? r_idx : '0;
  assign out_nan   = out_valid && r_nan;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_count <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_nan   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count <= '0;
            r_nan   <= 1'b0;
            r_idx   <= '0;
            if (len == '0) begin
              r_acc   <= NEG_INF_W;
              r_state <= S_DONE;
            end else begin
              r_len   <= len;
              r_state <= S_ACCUM;
            end
          end
        end

        S_ACCUM: begin
          if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
            if (w_in_nan) begin
              // First NaN pins the index; the accumulator never takes a NaN.
              if (!r_nan) begin
                r_nan <= 1'b1;
                r_idx <= r_count;
              end
            end else if ((r_count == '0) || w_in_gt) begin
              r_acc <= in_data;
              if (!r_nan) begin
                r_idx <= r_count;
              end
            end
            if (w_last) begin
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
